// File: rtl/relu_maxpool_2x2_if.sv
// Streaming sample bus into and pooled result bus out of relu_maxpool_2x2.
interface relu_maxpool_2x2_if #(
  parameter int unsigned WIDTH = 21
);
  logic                    data_valid_in;
  logic signed [WIDTH-1:0] pixel_in;
  logic [4:0]              hcount_in;
  logic [4:0]              vcount_in;
  logic                    data_valid_out;
  logic signed [WIDTH-1:0] pixel_out;
  logic [3:0]              hcount_out;
  logic [3:0]              vcount_out;
  logic                    frame_done_out;
  logic                    order_err_out;

  // Producer side: the convolution stage (or a bench standing in for it).
  modport master (
    output data_valid_in, pixel_in, hcount_in, vcount_in,
    input  data_valid_out, pixel_out, hcount_out, vcount_out,
           frame_done_out, order_err_out
  );

  // Pooling stage side.
  modport slave (
    input  data_valid_in, pixel_in, hcount_in, vcount_in,
    output data_valid_out, pixel_out, hcount_out, vcount_out,
           frame_done_out, order_err_out
  );
endinterface

// File: rtl/relu_maxpool_2x2.sv
// Streaming ReLU + 2x2 max-pool. Stage 1 pairs horizontal neighbours,
// stage 2 combines them with the half-width row buffer from the even row.
// Build option: define MAXPOOL_RELU_EN to clamp negative samples to zero
// before pooling; otherwise pooling is a pure signed max.
module relu_maxpool_2x2 #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned IMG_W = 24,
  parameter int unsigned IMG_H = 24
) (
  input logic                clk_in,
  input logic                rst_in,
  relu_maxpool_2x2_if.slave  bus
);
  localparam int unsigned POOL_W = IMG_W / 2;
  localparam int unsigned POOL_H = IMG_H / 2;

  // Stage 1 state: the pending even-column sample
  logic                    pair_pending;
  logic signed [WIDTH-1:0] pair_reg;
  logic [4:0]              pair_col;
  logic [4:0]              pair_row;

  // Stage 1 -> stage 2 pipeline register
  logic                    s1_valid;
  logic signed [WIDTH-1:0] s1_max;
  logic [3:0]              s1_k;
  logic [4:0]              s1_row;

  // Row buffer of even-row pair maxima plus per-entry valid bitmap
  logic signed [WIDTH-1:0] rowbuf [POOL_W];
  logic [POOL_W-1:0]       rowbuf_vld;

  logic                    in_range_c;
  logic                    pair_hit_c;
  logic signed [WIDTH-1:0] v_c;
  logic signed [WIDTH-1:0] pair_max_c;
  logic signed [WIDTH-1:0] rb_q_c;
  logic signed [WIDTH-1:0] pool_max_c;

  // Input gating, optional ReLU and horizontal/vertical max selection
  always_comb begin
    in_range_c = bus.data_valid_in
                 && (32'(bus.hcount_in) < IMG_W)
                 && (32'(bus.vcount_in) < IMG_H);
`ifdef MAXPOOL_RELU_EN
    v_c = bus.pixel_in[WIDTH-1] ? '0 : bus.pixel_in;
`else
    v_c = bus.pixel_in;
`endif
    pair_hit_c = pair_pending
                 && (bus.hcount_in == pair_col + 5'd1)
                 && (bus.vcount_in == pair_row);
    pair_max_c = (v_c > pair_reg) ? v_c : pair_reg;
    rb_q_c     = rowbuf[s1_k];
    pool_max_c = (s1_max > rb_q_c) ? s1_max : rb_q_c;
  end

  // Control, pipeline and registered outputs
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pair_pending       <= 1'b0;
      pair_reg           <= '0;
      pair_col           <= '0;
      pair_row           <= '0;
      s1_valid           <= 1'b0;
      s1_max             <= '0;
      s1_k               <= '0;
      s1_row             <= '0;
      rowbuf_vld         <= '0;
      bus.data_valid_out <= 1'b0;
      bus.pixel_out      <= '0;
      bus.hcount_out     <= '0;
      bus.vcount_out     <= '0;
      bus.frame_done_out <= 1'b0;
      bus.order_err_out  <= 1'b0;
    end else begin
      s1_valid           <= 1'b0;
      bus.data_valid_out <= 1'b0;
      bus.frame_done_out <= 1'b0;

      if (in_range_c) begin
        if (!bus.hcount_in[0]) begin
          if (pair_pending) bus.order_err_out <= 1'b1;
          pair_reg     <= v_c;
          pair_pending <= 1'b1;
          pair_col     <= bus.hcount_in;
          pair_row     <= bus.vcount_in;
        end else if (pair_hit_c) begin
          pair_pending <= 1'b0;
          s1_valid     <= 1'b1;
          s1_max       <= pair_max_c;
          s1_k         <= bus.hcount_in[4:1];
          s1_row       <= bus.vcount_in;
        end else begin
          bus.order_err_out <= 1'b1;
        end
      end

      if (s1_valid) begin
        if (!s1_row[0]) begin
          rowbuf_vld[s1_k] <= 1'b1;
        end else if (rowbuf_vld[s1_k]) begin
          rowbuf_vld[s1_k]   <= 1'b0;
          bus.data_valid_out <= 1'b1;
          bus.pixel_out      <= pool_max_c;
          bus.hcount_out     <= s1_k;
          bus.vcount_out     <= s1_row[4:1];
          bus.frame_done_out <= (s1_k == 4'(POOL_W - 1))
                                && (s1_row[4:1] == 4'(POOL_H - 1));
        end else begin
          bus.order_err_out <= 1'b1;
        end
      end
    end
  end

  // Row buffer data: written on even-row pairs, never needs reset
  always_ff @(posedge clk_in) begin
    if (s1_valid && !s1_row[0]) rowbuf[s1_k] <= s1_max;
  end
endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// Self-checking bench for relu_maxpool_2x2: directed windows, full frames,
// bubbles, ordering errors and mid-frame reset against a frame-array model.
module tb_relu_maxpool_2x2;
  localparam int unsigned WIDTH = 21;
  localparam int unsigned IMG_W = 24;
  localparam int unsigned IMG_H = 24;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;

  relu_maxpool_2x2_if #(.WIDTH(WIDTH)) bus ();

  relu_maxpool_2x2 #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    longint pix;
    int     h;
    int     v;
    int     fd;
    int     due;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     failures = 0;
  int     pc = 0;
  int     n_out = 0;
  longint img[IMG_W][IMG_H];
  bit     seen[IMG_W][IMG_H];

  always @(posedge clk_in) pc <= pc + 1;

  task automatic check(input string tag, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic longint act(input longint p);
`ifdef MAXPOOL_RELU_EN
    return (p < 0) ? 64'sd0 : p;
`else
    return p;
`endif
  endfunction

  function automatic longint rnd_pix();
    logic signed [WIDTH-1:0] r;
    r = WIDTH'($urandom);
    return longint'(r);
  endfunction

  // Drive one sample; the model records the frame and predicts window results
  task automatic send(input int h, input int v, input longint p);
    exp_t   e;
    longint m;
    @(negedge clk_in);
    bus.data_valid_in = 1'b1;
    bus.hcount_in     = 5'(h);
    bus.vcount_in     = 5'(v);
    bus.pixel_in      = WIDTH'(p);
    if (h < int'(IMG_W) && v < int'(IMG_H)) begin
      img[h][v]  = act(p);
      seen[h][v] = 1'b1;
      if ((h % 2 == 1) && (v % 2 == 1)
          && seen[h-1][v] && seen[h][v-1] && seen[h-1][v-1]) begin
        m = img[h][v];
        if (img[h-1][v]   > m) m = img[h-1][v];
        if (img[h][v-1]   > m) m = img[h][v-1];
        if (img[h-1][v-1] > m) m = img[h-1][v-1];
        e.pix = m;
        e.h   = h / 2;
        e.v   = v / 2;
        e.fd  = ((h / 2 == int'(IMG_W / 2) - 1) && (v / 2 == int'(IMG_H / 2) - 1)) ? 1 : 0;
        e.due = pc + 2;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      @(negedge clk_in);
      bus.data_valid_in = 1'b0;
      repeat (n - 1) @(negedge clk_in);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    for (int h = 0; h < int'(IMG_W); h++)
      for (int v = 0; v < int'(IMG_H); v++) seen[h][v] = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk_in);
    rst_in            = 1'b0;
    bus.data_valid_in = 1'b0;
    clear_model();
    repeat (2) @(negedge clk_in);
    check("rst_valid", longint'(bus.data_valid_out), 0);
    check("rst_pixel", longint'(bus.pixel_out), 0);
    check("rst_hcount", longint'(bus.hcount_out), 0);
    check("rst_vcount", longint'(bus.vcount_out), 0);
    check("rst_frame_done", longint'(bus.frame_done_out), 0);
    check("rst_order_err", longint'(bus.order_err_out), 0);
    rst_in = 1'b1;
  endtask

  // mode 0: pixel=h+32v; mode 1: random. gap<0: random bubbles plus stray
  // out-of-range samples that must be ignored.
  task automatic send_frame(input int mode, input int gap);
    for (int v = 0; v < int'(IMG_H); v++) begin
      for (int h = 0; h < int'(IMG_W); h++) begin
        if (gap < 0 && $urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 1) == 0)
            send(int'($urandom_range(IMG_W, 31)), v, rnd_pix());
          else
            send(h, int'($urandom_range(IMG_H, 31)), rnd_pix());
        end
        send(h, v, (mode == 0) ? longint'(h + 32 * v) : rnd_pix());
        idle((gap < 0) ? int'($urandom_range(0, 2)) : gap);
      end
    end
    idle(4);
  endtask

  // Output monitor: every due prediction must appear exactly on its cycle
  always @(negedge clk_in) begin
    if (rst_in) begin
      if (exp_q.size() > 0 && exp_q[0].due <= pc) begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_valid", longint'(bus.data_valid_out), 1);
        if (bus.data_valid_out) begin
          n_out++;
          check("out_pixel", longint'(bus.pixel_out), e.pix);
          check("out_hcount", longint'(bus.hcount_out), longint'(e.h));
          check("out_vcount", longint'(bus.vcount_out), longint'(e.v));
          check("out_frame_done", longint'(bus.frame_done_out), longint'(e.fd));
        end
      end else if (bus.data_valid_out) begin
        check("unexpected_out", longint'(bus.data_valid_out), 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    bus.data_valid_in = 1'b0;
    bus.pixel_in      = '0;
    bus.hcount_in     = '0;
    bus.vcount_in     = '0;
    reset_dut();

    // Mixed-sign window
    send(0, 0, 5); send(1, 0, -3); send(0, 1, 9); send(1, 1, 2);
    idle(5);
    check("win_pixel_hold", longint'(bus.pixel_out), 9);

    // All-negative window
    send(0, 0, -20); send(1, 0, -7); send(0, 1, -100); send(1, 1, -1);
    idle(5);
`ifdef MAXPOOL_RELU_EN
    check("neg_pixel_hold", longint'(bus.pixel_out), 0);
`else
    check("neg_pixel_hold", longint'(bus.pixel_out), -1);
`endif
    check("err_after_windows", longint'(bus.order_err_out), 0);

    // Full ramp frame back-to-back, then with 3 idle cycles between samples
    reset_dut();
    base = n_out;
    send_frame(0, 0);
    check("ramp_count", longint'(n_out - base), 144);
    check("ramp_last_pixel", longint'(bus.pixel_out), 23 + 32 * 23);
    check("ramp_err", longint'(bus.order_err_out), 0);
    base = n_out;
    send_frame(0, 3);
    check("ramp_gap_count", longint'(n_out - base), 144);

    // Random frame, random bubbles, stray out-of-range samples
    base = n_out;
    send_frame(1, -1);
    check("rand_count", longint'(n_out - base), 144);
    check("rand_err", longint'(bus.order_err_out), 0);

    // Odd row without its even row
    reset_dut();
    send(0, 1, 11); send(1, 1, 12);
    idle(4);
    check("row_order_err", longint'(bus.order_err_out), 1);
    idle(6);
    check("row_order_err_sticky", longint'(bus.order_err_out), 1);

    // Odd column without its even column; processing continues afterwards
    reset_dut();
    send(0, 0, 1); send(1, 0, 2); send(3, 0, 4);
    idle(3);
    check("col_order_err", longint'(bus.order_err_out), 1);
    send(2, 0, 7); send(3, 0, 6); send(2, 1, -2); send(3, 1, 8);
    idle(4);
    check("col_err_continue", longint'(bus.pixel_out), 8);

    // Reset after half of row 1, then a clean random frame
    reset_dut();
    for (int h = 0; h < int'(IMG_W); h++) send(h, 0, rnd_pix());
    for (int h = 0; h < int'(IMG_W) / 2; h++) send(h, 1, rnd_pix());
    idle(4);
    reset_dut();
    base = n_out;
    send_frame(1, 0);
    check("post_reset_count", longint'(n_out - base), 144);
    check("post_reset_err", longint'(bus.order_err_out), 0);

    idle(4);
    check("drain", longint'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
